// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port character RAM arbiter: display fetch, host write FIFO, clear engine
module vram_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLEAR_LEN  = 2000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_valid,
    output logic [DATA_W-1:0] disp_data,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              clr_done,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(CLEAR_LEN - 1);
    localparam logic [CNT_W-1:0]  FIFO_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_FILL = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic [DATA_W-1:0] clr_val_q, clr_val_d;

    logic              clr_gnt, host_gnt;
    logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;

    logic [1:0]        rd_vld_q;
    logic              disp_valid_q;
    logic [DATA_W-1:0] disp_data_q;

    // Full means not ready even if the head pops this cycle.
    assign host_ready = (count_q < FIFO_FULL);
    assign push       = host_valid & host_ready;
    assign pop        = host_gnt;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= host_addr;
            fifo_data_q[wr_ptr_q] <= host_wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Display always wins; host pops are held off for the whole clear, including DONE.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_val_d = clr_val_q;
        clr_gnt   = 1'b0;
        host_gnt  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                host_gnt = !disp_req && (count_q != '0);
                if (clr_start && (count_q == '0)) begin
                    state_d   = CLR_FILL;
                    clr_cnt_d = '0;
                    clr_val_d = clr_value;
                end
            end
            CLR_FILL: begin
                if (!disp_req) begin
                    clr_gnt   = 1'b1;
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                    if (clr_cnt_q == CLR_LAST) state_d = CLR_DONE;
                end
            end
            CLR_DONE: state_d = CLR_IDLE;
            default:  state_d = CLR_IDLE;
        endcase
    end

    always_comb begin
        ram_en_d    = disp_req | clr_gnt | host_gnt;
        ram_we_d    = clr_gnt | host_gnt;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        if (disp_req) begin
            ram_addr_d = disp_addr;
        end else if (clr_gnt) begin
            ram_addr_d  = clr_cnt_q;
            ram_wdata_d = clr_val_q;
        end else if (host_gnt) begin
            ram_addr_d  = fifo_addr_q[rd_ptr_q];
            ram_wdata_d = fifo_data_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= CLR_IDLE;
            clr_cnt_q    <= '0;
            clr_val_q    <= '0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rd_vld_q     <= 2'b00;
            disp_valid_q <= 1'b0;
            disp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clr_val_q    <= clr_val_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rd_vld_q     <= {rd_vld_q[0], disp_req};
            disp_valid_q <= rd_vld_q[1];
            if (rd_vld_q[1]) disp_data_q <= ram_rdata;
        end
    end

    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;
    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_data_q;
    assign clr_busy   = (state_q == CLR_FILL);
    assign clr_done   = (state_q == CLR_DONE);

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

    logic        clock;
    logic        reset_n;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        host_valid;
    logic        host_ready;
    logic [10:0] host_addr;
    logic [7:0]  host_wdata;
    logic        clr_start;
    logic [7:0]  clr_value;
    logic        clr_busy;
    logic        clr_done;
    logic        ram_en;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [10:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t        wlog[$];
    logic [7:0] mem [2048];

    vram_arbiter #(
        .ADDR_W(11), .DATA_W(8), .FIFO_DEPTH(4), .CLEAR_LEN(16)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .clr_start(clr_start), .clr_value(clr_value),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial ram_rdata = 8'h00;
    always @(posedge clock) begin
        if (ram_en && ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wlog.push_back('{ram_addr, ram_wdata});
        end
        if (ram_en && !ram_we) begin
            if (ram_addr == 11'h005)      ram_rdata <= 8'h41;
            else if (ram_addr == 11'h7FF) ram_rdata <= 8'h55;
            else                          ram_rdata <= mem[ram_addr];
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string ph);
        chk({ph, "_ram_en"},     32'(ram_en),     0);
        chk({ph, "_ram_we"},     32'(ram_we),     0);
        chk({ph, "_ram_addr"},   32'(ram_addr),   0);
        chk({ph, "_ram_wdata"},  32'(ram_wdata),  0);
        chk({ph, "_disp_valid"}, 32'(disp_valid), 0);
        chk({ph, "_disp_data"},  32'(disp_data),  0);
        chk({ph, "_host_ready"}, 32'(host_ready), 1);
        chk({ph, "_clr_busy"},   32'(clr_busy),   0);
        chk({ph, "_clr_done"},   32'(clr_done),   0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int wb;
        int busy;
        int done_at;
        int errs;
        reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0;
        host_valid = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0; clr_value = '0;
        repeat (3) tick();
        chk_reset("rst");
        reset_n = 1'b1;
        tick();

        // single display fetch, latency 3
        disp_req = 1'b1; disp_addr = 11'h005;
        chk_reset("pre_t1");
        tick();
        disp_req = 1'b0;
        chk("t1_en",   32'(ram_en),     1);
        chk("t1_we",   32'(ram_we),     0);
        chk("t1_addr", 32'(ram_addr),   'h005);
        chk("t1_v1",   32'(disp_valid), 0);
        tick();
        chk("t1_en2",  32'(ram_en),     0);
        chk("t1_v2",   32'(disp_valid), 0);
        tick();
        chk("t1_v3",   32'(disp_valid), 1);
        chk("t1_data", 32'(disp_data),  'h41);
        tick();
        chk("t1_v4",   32'(disp_valid), 0);

        // fill FIFO while display holds the port, then drain with one collision
        wb = wlog.size();
        disp_addr = 11'h7FF; disp_req = 1'b1; host_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            host_addr  = 11'(16 + i);
            host_wdata = 8'(160 + i);
            chk("a_rdy", 32'(host_ready), 1);
            tick();
        end
        disp_req = 1'b0; host_addr = 11'h3FF; host_wdata = 8'hEE;
        chk("a_full",    32'(host_ready), 0);
        chk("a_p4_en",   32'(ram_en),     1);
        chk("a_p4_we",   32'(ram_we),     0);
        tick();
        host_valid = 1'b0; disp_req = 1'b1;
        chk("a_w0_we",   32'(ram_we),     1);
        chk("a_w0_addr", 32'(ram_addr),   'h010);
        chk("a_w0_data", 32'(ram_wdata),  'hA0);
        chk("a_rdy_back",32'(host_ready), 1);
        tick();
        disp_req = 1'b0;
        chk("a_col_en",   32'(ram_en),   1);
        chk("a_col_we",   32'(ram_we),   0);
        chk("a_col_addr", 32'(ram_addr), 'h7FF);
        tick();
        chk("a_w1_we",   32'(ram_we),     1);
        chk("a_w1_addr", 32'(ram_addr),   'h011);
        chk("a_w1_data", 32'(ram_wdata),  'hA1);
        chk("a_p7_dv",   32'(disp_valid), 0);
        tick();
        chk("a_w2_addr", 32'(ram_addr),   'h012);
        chk("a_w2_data", 32'(ram_wdata),  'hA2);
        chk("a_p8_dv",   32'(disp_valid), 1);
        chk("a_p8_dd",   32'(disp_data),  'h55);
        tick();
        chk("a_w3_we",   32'(ram_we),     1);
        chk("a_w3_addr", 32'(ram_addr),   'h013);
        chk("a_w3_data", 32'(ram_wdata),  'hA3);
        tick();
        chk("a_idle_en",   32'(ram_en),   0);
        chk("a_idle_we",   32'(ram_we),   0);
        chk("a_hold_addr", 32'(ram_addr), 'h013);
        chk("a_nwrites",   32'(wlog.size() - wb), 4);

        // clear of 16 cells with two display collisions and a host write during FILL
        wb = wlog.size();
        clr_value = 8'h20; clr_start = 1'b1;
        chk("b_busy0", 32'(clr_busy), 0);
        tick();
        clr_start = 1'b0;
        busy = 0; done_at = -1;
        for (int i = 0; i < 40 && done_at < 0; i++) begin
            if (clr_busy) busy++;
            if (clr_done) begin
                done_at = i;
                chk("b_last_we",   32'(ram_we),   1);
                chk("b_last_addr", 32'(ram_addr), 15);
            end
            disp_req   = (i == 2 || i == 7);
            host_valid = (i == 4);
            host_addr  = 11'h200;
            host_wdata = 8'h77;
            if (i == 4) chk("b_push_rdy", 32'(host_ready), 1);
            tick();
        end
        disp_req = 1'b0; host_valid = 1'b0;
        chk("b_done_at", 32'(done_at), 18);
        chk("b_busy_len", 32'(busy), 18);
        chk("b_done_once", 32'(clr_done), 0);
        tick();
        tick();
        chk("b_nwrites", 32'(wlog.size() - wb), 17);
        errs = 0;
        for (int j = 0; j < 16 && wb + j < wlog.size(); j++) begin
            if (wlog[wb + j].a !== 11'(j) || wlog[wb + j].d !== 8'h20) errs++;
        end
        chk("b_fill_ok", 32'(errs), 0);
        if (wlog.size() > wb + 16) begin
            chk("b_host_addr", 32'(wlog[wb + 16].a), 'h200);
            chk("b_host_data", 32'(wlog[wb + 16].d), 'h77);
        end

        // clr_start with a non-empty FIFO is ignored
        wb = wlog.size();
        host_valid = 1'b1; host_addr = 11'h300; host_wdata = 8'h99;
        tick();
        host_valid = 1'b0; disp_req = 1'b1; clr_start = 1'b1; clr_value = 8'h33;
        tick();
        clr_start = 1'b0; disp_req = 1'b0;
        chk("c_busy", 32'(clr_busy), 0);
        tick();
        chk("c_we",   32'(ram_we),    1);
        chk("c_addr", 32'(ram_addr),  'h300);
        chk("c_data", 32'(ram_wdata), 'h99);
        errs = 0;
        repeat (20) begin
            if (clr_done || clr_busy) errs++;
            tick();
        end
        chk("c_no_clear", 32'(errs), 0);
        chk("c_nwrites",  32'(wlog.size() - wb), 1);

        // async reset mid-FILL with a display read in flight
        clr_value = 8'h5A; clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick();
        tick();
        disp_req = 1'b1; disp_addr = 11'h005;
        tick();
        disp_req = 1'b0;
        chk("d_busy", 32'(clr_busy), 1);
        chk("d_rd_en", 32'(ram_en), 1);
        chk("d_rd_we", 32'(ram_we), 0);
        #1 reset_n = 1'b0;
        #1 chk_reset("d_async");
        tick();
        tick();
        reset_n = 1'b1;
        errs = 0;
        repeat (5) begin
            if (disp_valid) errs++;
            tick();
        end
        chk("d_no_dv",   32'(errs),       0);
        chk("d_busy2",   32'(clr_busy),   0);
        chk("d_ready",   32'(host_ready), 1);
        chk("d_ram_en",  32'(ram_en),     0);
        chk("d_done",    32'(clr_done),   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter and sequencer for the text-mode display path. It shares one synchronous character RAM between three requesters: the scan-out character fetch, a buffered host write port, and a built-in screen-clear engine. Scan-out fetches are served in the cycle they are requested, so the beam never stalls. The block sits between the VGA timing/fetch logic on the pixel clock and the RAM holding the 80x25 character codes that index the font ROM.

## Interface

Parameters:
- ADDR_W, 11, RAM address width (2048 cells).
- DATA_W, 8, character code width.
- FIFO_DEPTH, 4, host write FIFO entries (power of two, 2..16).
- CLEAR_LEN, 2000, number of cells written by the clear engine (80x25), 1..2^ADDR_W.

Ports:
- clock  in  1  pixel clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- disp_req  in  1  scan-out fetch strobe; always granted in the same cycle.
- disp_addr  in  ADDR_W  scan-out fetch address.
- disp_valid  out  1  one-cycle pulse: disp_data holds a fetched code.
- disp_data  out  DATA_W  fetched character code (registered).
- host_valid  in  1  host write offered.
- host_ready  out  1  FIFO can accept; a write transfers on host_valid & host_ready.
- host_addr  in  ADDR_W  host write address.
- host_wdata  in  DATA_W  host write data.
- clr_start  in  1  clear request pulse.
- clr_value  in  DATA_W  fill code, sampled on accepted clr_start.
- clr_busy  out  1  clear engine in FILL.
- clr_done  out  1  one-cycle pulse after final clear write is issued.
- ram_en  out  1  RAM access enable (registered).
- ram_we  out  1  RAM write enable (registered).
- ram_addr  out  ADDR_W  RAM address (registered).
- ram_wdata  out  DATA_W  RAM write data (registered).
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after ram_en & !ram_we.

## Operation

- One RAM grant per cycle, fixed priority: disp_req > clear engine (FILL) > host FIFO head.
- Granted request is registered onto ram_en/ram_we/ram_addr/ram_wdata the next cycle. With no grant, ram_en = ram_we = 0. ram_addr and ram_wdata hold their previous values.
- Host FIFO:
  - host_ready = (count < FIFO_DEPTH). There is no accept-when-full, even if a pop happens in the same cycle.
  - Simultaneous push and pop at any count other than full leaves count unchanged.
  - Writes are applied in acceptance order.
- Host pops are inhibited while clear state is FILL or DONE. Writes accepted during a clear land after it.
- Clear FSM states:
  - IDLE: clr_start accepted only if FIFO is empty. Latch clr_value, set addr counter to 0, go to FILL. clr_start with a non-empty FIFO is ignored, with no effect and no clr_done.
  - FILL: each cycle without disp_req, issue a write of clr_value to the counter address and increment the counter. After the grant at address CLEAR_LEN-1, go to DONE. clr_start is ignored.
  - DONE: clr_done = 1 for one cycle, then go to IDLE.
- Read pipeline: 2-bit valid shift tracks disp grants. disp_data <= ram_rdata and disp_valid = 1 two cycles after ram_en.

## Timing

- Reset (async assert, sync deassert expected): ram_en = ram_we = 0, ram_addr = 0, ram_wdata = 0, disp_valid = 0, disp_data = 0, host_ready = 1, clr_busy = 0, clr_done = 0. FIFO is emptied, clear state is IDLE, and in-flight reads are dropped.
- Display: disp_req at cycle t → ram_en/ram_addr at t+1 → ram_rdata at t+2 → disp_valid/disp_data at t+3. Fixed latency 3 with no jitter. Back-to-back requests give back-to-back results.
- Host: accepted at t into an empty FIFO → ram_we at t+2 at the earliest, if t+1 has no display or clear grant. There is no FIFO bypass.
- Clear: clr_start at t → clr_busy from t+1 → first write (address 0) on ram_we at t+2 if no disp_req at t+1.
  - With no display contention, clr_busy lasts exactly CLEAR_LEN cycles.
  - clr_done pulses in the same cycle the final write appears on the RAM port.
- clr_start and host push in the same cycle: the clear is accepted only if the FIFO was empty before that cycle. The pushed write lands after the clear.
- Each disp_req cycle delays the pending clear/host grant by one cycle. No requester is ever starved beyond the display duty.

## Test plan

- Reset, then disp_req at addr 0x005 with a RAM model returning 0x41 → ram_en = 1, ram_addr = 0x005 at t+1. disp_valid = 1, disp_data = 0x41 at t+3. All outputs equal their reset values before t+1.
- Four host writes (0x010..0x013, data 0xA0..0xA3) with no display activity:
  - host_ready drops after the fourth accept when it is not drained.
  - ram_we pulses appear in order, addresses 0x010..0x013.
  - host_ready returns to 1.
- disp_req every 8th cycle while the host FIFO is full → display grants are never delayed. Host writes are delayed by exactly one cycle at each collision and all four complete.
- clr_start with clr_value = 0x20 and CLEAR_LEN = 16, with disp_req on 2 of those cycles:
  - 16 writes to addresses 0..15, all with data 0x20.
  - clr_busy lasts 18 cycles, then clr_done pulses once.
- clr_start while the FIFO holds one entry → clear ignored (clr_busy stays 0, no clr_done) and the host write completes. A host write accepted during FILL reaches RAM only after clr_done.
- reset_n asserted mid-FILL with a disp_req in flight → outputs return to reset values immediately, disp_valid does not fire, and after release state is IDLE with host_ready = 1.
